// File: rtl/uart_transmitter_pkg.sv
//=============================================================================
// Package  : UART_pkg
// Brief    : Shared types, encodings and helpers for the UART transmitter.
// Revision : 1.0 - initial release
//=============================================================================
`default_nettype none

package UART_pkg;

   localparam int TICKS_PER_BIT = 16;

   typedef enum logic [1:0] {
      DW_5 = 2'd0,
      DW_6 = 2'd1,
      DW_7 = 2'd2,
      DW_8 = 2'd3
   } data_width_e;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_e;

   typedef enum logic {
      STOP_1 = 1'b0,
      STOP_2 = 1'b1
   } stop_bits_e;

   typedef struct packed {
      data_width_e width;
      parity_e     parity;
      stop_bits_e  stop;
   } uart_config_s;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_e;

   localparam uart_config_s CFG_RESET = '{width: DW_8, parity: PAR_NONE, stop: STOP_1};

   // Index of the final data bit for a given width (5 bits -> 4 ... 8 bits -> 7).
   function automatic logic [2:0] last_bit(input data_width_e w);
      return 3'd4 + {1'b0, w};
   endfunction

   function automatic logic [7:0] width_mask(input data_width_e w);
      case (w)
         DW_5:    return 8'h1F;
         DW_6:    return 8'h3F;
         DW_7:    return 8'h7F;
         default: return 8'hFF;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_transmitter.sv
//=============================================================================
// Module   : uart_transmitter
// Brief    : Configurable 5-8 bit UART transmitter fed by a FWFT FIFO.
// Revision : 1.0 - initial release
//=============================================================================
`default_nettype none

module uart_transmitter
   import UART_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         baud_rt_tick_i,
   input  logic         tx_fifo_empty_i,
   input  logic [7:0]   tx_data_i,
   output logic         tx_fifo_read_o,
   input  logic         config_en_i,
   input  uart_config_s config_i,
   output logic         tx_o,
   output logic         is_transmitting_o,
   output logic         tx_done_o
);

   state_e       state_q, state_d;
   logic [3:0]   tick_cnt_q, tick_cnt_d;
   logic [2:0]   bit_cnt_q, bit_cnt_d;
   logic [7:0]   data_q, data_d;
   uart_config_s cfg_q, cfg_d;
   logic         tx_q, tx_d;
   logic         bit_end;
   logic         parity_bit;
   logic         fifo_pop;
   logic         frame_done;

   assign bit_end    = baud_rt_tick_i && (tick_cnt_q == 4'(TICKS_PER_BIT - 1));
   assign parity_bit = (^(data_q & width_mask(cfg_q.width))) ^ (cfg_q.parity == PAR_ODD);

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      data_d     = data_q;
      cfg_d      = cfg_q;
      fifo_pop   = 1'b0;
      frame_done = 1'b0;

      if (state_q != IDLE && baud_rt_tick_i) begin
         tick_cnt_d = tick_cnt_q + 4'd1;
      end

      case (state_q)
         IDLE: begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            if (config_en_i) begin
               cfg_d = config_i;
            end else if (!tx_fifo_empty_i) begin
               fifo_pop = 1'b1;
               data_d   = tx_data_i;
               state_d  = START;
            end
         end
         START: begin
            if (bit_end) state_d = DATA;
         end
         DATA: begin
            if (bit_end) begin
               if (bit_cnt_q == last_bit(cfg_q.width)) begin
                  bit_cnt_d = '0;
                  state_d   = (cfg_q.parity == PAR_NONE) ? STOP : PARITY;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         PARITY: begin
            if (bit_end) state_d = STOP;
         end
         STOP: begin
            // bit_cnt is reused to remember that the first of two stop bits is done.
            if (bit_end) begin
               if (cfg_q.stop == STOP_2 && bit_cnt_q == 3'd0) begin
                  bit_cnt_d = 3'd1;
               end else begin
                  frame_done = 1'b1;
                  state_d    = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = data_d[bit_cnt_d];
         PARITY:  tx_d = parity_bit;
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         data_q     <= '0;
         cfg_q      <= CFG_RESET;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         data_q     <= data_d;
         cfg_q      <= cfg_d;
         tx_q       <= tx_d;
      end
   end

   assign tx_o              = tx_q;
   assign tx_fifo_read_o    = fifo_pop && !rst_i;
   assign is_transmitting_o = (state_q != IDLE);
   assign tx_done_o         = frame_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_transmitter.sv
//=============================================================================
// Module   : tb_uart_transmitter
// Brief    : Self-checking bench: frame vectors, reset corner case, random traffic.
// Revision : 1.0 - initial release
//=============================================================================
`default_nettype none

module tb_uart_transmitter;
   import UART_pkg::*;

   logic         clk = 1'b0;
   logic         rst_i;
   logic         baud_rt_tick_i;
   logic         tx_fifo_empty_i;
   logic [7:0]   tx_data_i;
   logic         tx_fifo_read_o;
   logic         config_en_i;
   uart_config_s config_i;
   logic         tx_o;
   logic         is_transmitting_o;
   logic         tx_done_o;

   uart_transmitter dut (
      .clk_i             (clk),
      .rst_i             (rst_i),
      .baud_rt_tick_i    (baud_rt_tick_i),
      .tx_fifo_empty_i   (tx_fifo_empty_i),
      .tx_data_i         (tx_data_i),
      .tx_fifo_read_o    (tx_fifo_read_o),
      .config_en_i       (config_en_i),
      .config_i          (config_i),
      .tx_o              (tx_o),
      .is_transmitting_o (is_transmitting_o),
      .tx_done_o         (tx_done_o)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]   fifo[$];
   int           tick_pct = 100;
   logic         pop_s;

   // reference model: frame as a list of line levels, one per bit period
   uart_config_s m_cfg;
   logic         m_busy;
   logic [15:0]  m_frame;
   int           m_len;
   int           m_tick;

   // recorder for table vectors
   logic [31:0]  rec_seq;
   int           rec_ticks, rec_pops, rec_dones;
   int           cyc_n, last_done_cyc, gap;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic uart_config_s mk_cfg(input data_width_e w, input parity_e p, input stop_bits_e s);
      uart_config_s c;
      c.width = w; c.parity = p; c.stop = s;
      return c;
   endfunction

   task automatic drive_fifo();
      tx_fifo_empty_i = (fifo.size() == 0);
      tx_data_i       = (fifo.size() == 0) ? 8'hxx : fifo[0];
   endtask

   task automatic build_frame(input logic [7:0] d, input uart_config_s c);
      int w;
      int ones;
      w = 5 + int'(c.width);
      ones = 0;
      m_frame = '1;
      m_frame[0] = 1'b0;
      for (int i = 0; i < w; i++) begin
         m_frame[1 + i] = d[i];
         ones += int'(d[i]);
      end
      m_len = 1 + w;
      if (c.parity != PAR_NONE) begin
         m_frame[m_len] = (c.parity == PAR_ODD) ? ((ones % 2) == 0) : ((ones % 2) == 1);
         m_len++;
      end
      m_len += (c.stop == STOP_2) ? 2 : 1;
   endtask

   task automatic model_check();
      if (rst_i) begin
         chk("rst_tx", tx_o, 1);
         chk("rst_read", tx_fifo_read_o, 0);
         chk("rst_busy", is_transmitting_o, 0);
         chk("rst_done", tx_done_o, 0);
         m_busy = 1'b0;
         m_cfg  = CFG_RESET;
      end else if (!m_busy) begin
         chk("idle_tx", tx_o, 1);
         chk("idle_busy", is_transmitting_o, 0);
         chk("idle_done", tx_done_o, 0);
         chk("idle_read", tx_fifo_read_o, !tx_fifo_empty_i && !config_en_i);
         if (config_en_i) begin
            m_cfg = config_i;
         end else if (!tx_fifo_empty_i) begin
            build_frame(tx_data_i, m_cfg);
            m_busy = 1'b1;
            m_tick = 0;
         end
      end else begin
         chk("busy_flag", is_transmitting_o, 1);
         chk("busy_read", tx_fifo_read_o, 0);
         chk("line_level", tx_o, m_frame[m_tick / TICKS_PER_BIT]);
         if (baud_rt_tick_i) begin
            m_tick++;
            chk("frame_done", tx_done_o, m_tick == m_len * TICKS_PER_BIT);
            if (m_tick == m_len * TICKS_PER_BIT) m_busy = 1'b0;
         end else begin
            chk("frame_done", tx_done_o, 0);
         end
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      cyc_n++;
      pop_s = tx_fifo_read_o;
      if (!rst_i) begin
         if (is_transmitting_o && baud_rt_tick_i) begin
            if (rec_ticks % TICKS_PER_BIT == 0 && rec_ticks / TICKS_PER_BIT < 32)
               rec_seq[rec_ticks / TICKS_PER_BIT] = tx_o;
            rec_ticks++;
         end
         if (tx_done_o) begin
            rec_dones++;
            last_done_cyc = cyc_n;
         end
         if (tx_fifo_read_o) begin
            rec_pops++;
            if (rec_dones > 0) gap = cyc_n - last_done_cyc;
         end
      end
      model_check();
      @(posedge clk);
      #1;
      if (pop_s && fifo.size() > 0) void'(fifo.pop_front());
      baud_rt_tick_i = ($urandom_range(0, 99) < tick_pct);
      drive_fifo();
   endtask

   task automatic rec_clear();
      rec_seq = '0; rec_ticks = 0; rec_pops = 0; rec_dones = 0; gap = -1;
   endtask

   typedef struct {
      uart_config_s cfg;
      logic [7:0]   d0;
      logic [7:0]   d1;
      bit           two;
      bit           mid_en;
      uart_config_s mid_cfg;
      logic [31:0]  exp_seq;   // bit i = line level during bit period i
      int           exp_ticks;
   } vec_t;

   vec_t vecs[6];

   task automatic run_vec(input int idx, input vec_t v);
      int  need;
      bit  mid_done;
      need = v.two ? 2 : 1;
      mid_done = 1'b0;
      fifo.push_back(v.d0);
      if (v.two) fifo.push_back(v.d1);
      drive_fifo();
      config_i    = v.cfg;
      config_en_i = 1'b1;
      cyc();
      config_en_i = 1'b0;
      rec_clear();
      for (int t = 0; t < 2000 && rec_dones < need; t++) begin
         cyc();
         if (v.mid_en && !mid_done && rec_ticks >= 40) begin
            config_i    = v.mid_cfg;
            config_en_i = 1'b1;
            cyc();
            config_en_i = 1'b0;
            mid_done    = 1'b1;
         end
      end
      cyc();
      chk($sformatf("vec%0d_dones", idx), rec_dones, need);
      chk($sformatf("vec%0d_pops", idx), rec_pops, need);
      chk($sformatf("vec%0d_seq", idx), rec_seq, v.exp_seq);
      chk($sformatf("vec%0d_ticks", idx), rec_ticks, v.exp_ticks);
      if (v.two) chk($sformatf("vec%0d_gap", idx), gap, 1);
   endtask

   initial begin
      rst_i = 1'b1; baud_rt_tick_i = 1'b0; config_en_i = 1'b0;
      config_i = CFG_RESET; cyc_n = 0; last_done_cyc = 0;
      m_busy = 1'b0; m_cfg = CFG_RESET; m_tick = 0; m_len = 0; m_frame = '1;
      rec_clear();
      drive_fifo();
      repeat (3) cyc();
      rst_i = 1'b0;
      repeat (3) cyc();
      chk("post_rst_tx", tx_o, 1);
      chk("post_rst_busy", is_transmitting_o, 0);

      vecs[0] = '{mk_cfg(DW_8, PAR_NONE, STOP_1), 8'h55, 8'h00, 0, 0, CFG_RESET, 32'h2AA, 160};
      vecs[1] = '{mk_cfg(DW_7, PAR_EVEN, STOP_2), 8'hA3, 8'h00, 0, 0, CFG_RESET, 32'h746, 176};
      vecs[2] = '{mk_cfg(DW_8, PAR_ODD,  STOP_1), 8'h00, 8'h00, 0, 1,
                  mk_cfg(DW_5, PAR_NONE, STOP_2), 32'h600, 176};
      vecs[3] = '{mk_cfg(DW_8, PAR_NONE, STOP_1), 8'h12, 8'h34, 1, 0, CFG_RESET, 32'h9A224, 320};
      vecs[4] = '{mk_cfg(DW_5, PAR_ODD,  STOP_1), 8'hFF, 8'h00, 0, 0, CFG_RESET, 32'hBE, 128};
      vecs[5] = '{mk_cfg(DW_6, PAR_NONE, STOP_2), 8'h2A, 8'h00, 0, 0, CFG_RESET, 32'h1D4, 144};

      tick_pct = 100;
      for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

      // reset in the middle of data bit 3 of 0x55 (line low there)
      config_i = mk_cfg(DW_8, PAR_NONE, STOP_1);
      config_en_i = 1'b1;
      cyc();
      config_en_i = 1'b0;
      fifo.push_back(8'h55);
      drive_fifo();
      for (int t = 0; t < 300 && !(m_busy && m_tick >= 72); t++) cyc();
      chk("pre_rst_tx", tx_o, 0);
      rst_i = 1'b1;
      #1;
      chk("async_rst_tx", tx_o, 1);
      chk("async_rst_busy", is_transmitting_o, 0);
      chk("async_rst_done", tx_done_o, 0);
      rec_clear();
      repeat (3) cyc();
      rst_i = 1'b0;
      repeat (50) cyc();
      chk("post_abort_pops", rec_pops, 0);
      chk("post_abort_dones", rec_dones, 0);
      chk("post_abort_tx", tx_o, 1);

      // random traffic against the model
      tick_pct = 60;
      rec_clear();
      for (int t = 0; t < 6000; t++) begin
         config_en_i = ($urandom_range(0, 49) == 0);
         config_i = mk_cfg(data_width_e'(2'($urandom_range(0, 3))),
                           parity_e'(2'($urandom_range(0, 2))),
                           stop_bits_e'(1'($urandom_range(0, 1))));
         if (fifo.size() < 2 && $urandom_range(0, 7) == 0) begin
            fifo.push_back(8'($urandom()));
            drive_fifo();
         end
         cyc();
      end
      config_en_i = 1'b0;
      for (int t = 0; t < 3000 && (m_busy || fifo.size() != 0); t++) cyc();
      chk("rand_drained", m_busy, 0);
      chk("rand_pop_done", rec_dones, rec_pops);
      chk("rand_enough_frames", rec_dones >= 5, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
